// File: rtl/replay_loop_buffer.sv
// ---------------------------------------------------------------------------
// replay_loop_buffer
//
// Multi-channel record/playback loop buffer for the replay path. A true
// dual-port RAM holds frames of NUM_CH interleaved signed samples at word
// address {frame_ptr, ch_idx}. Port A takes record (and overdub) writes and
// port B serves playback reads. In RECORD each sample_tick stores one frame.
// In PLAY each tick replays one frame of the loop window
// [start_eff, end_eff).
//
// Optional feature: define REPLAY_OVERDUB_EN to enable overdub. When overdub
// is high at a PLAY tick, each word read is written back as
// saturate(old + rec_data[k]). Without the macro the overdub input is
// ignored.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   sample_tick        one-cycle frame strobe
//   cmd_record         pulse: start recording (wr_ptr, rec_len cleared)
//   cmd_play           pulse: start playback (ignored while rec_len == 0)
//   cmd_stop           pulse: return to IDLE, clear overrun
//   overdub            level: mix rec_data into the loop during PLAY
//   rec_data           input frame, ch0 in the LSBs
//   loop_start         first frame of the loop window
//   loop_end           exclusive end frame, 0 selects rec_len
//   play_data          output frame, ch0 in the LSBs
//   play_valid         one-cycle pulse marking new play_data
//   state              0 = IDLE, 1 = RECORD, 2 = PLAY
//   rec_len            number of frames recorded
//   busy               frame engine active
//   overrun            sticky: a tick arrived while the engine was busy
// ---------------------------------------------------------------------------
module replay_loop_buffer #(
    parameter  int ADDR_WIDTH = 17,
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_CH     = 2,
    localparam int CHB        = $clog2(NUM_CH),
    localparam int FW         = ADDR_WIDTH - CHB
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic                         cmd_record,
    input  logic                         cmd_play,
    input  logic                         cmd_stop,
    input  logic                         overdub,
    input  logic [NUM_CH*DATA_WIDTH-1:0] rec_data,
    input  logic [FW-1:0]                loop_start,
    input  logic [FW:0]                  loop_end,
    output logic [NUM_CH*DATA_WIDTH-1:0] play_data,
    output logic                         play_valid,
    output logic [1:0]                   state,
    output logic [FW:0]                  rec_len,
    output logic                         busy,
    output logic                         overrun
);

    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int FRAMES = 2**FW;
    localparam int CW     = (CHB > 0) ? CHB : 1;
    localparam int EW     = $clog2(NUM_CH + 4);

    localparam logic [EW-1:0] CNT_LAST = EW'(NUM_CH - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);
    localparam logic [FW:0]   LEN_FULL = (FW+1)'(FRAMES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2
    } state_e;

    // Encoded so that a larger value means a higher priority.
    typedef enum logic [1:0] {
        C_NONE = 2'd0,
        C_PLAY = 2'd1,
        C_REC  = 2'd2,
        C_STOP = 2'd3
    } cmd_e;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic signed [DATA_WIDTH-1:0] sat_add(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0] sum;
        sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
            sat_add = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            sat_add = sum[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] make_addr(
        input logic [FW-1:0] frame,
        input logic [CW-1:0] ch
    );
        make_addr = (ADDR_WIDTH'(frame) << CHB) | ADDR_WIDTH'(ch);
    endfunction

    function automatic logic [FW:0] calc_end(
        input logic [FW:0] len,
        input logic [FW:0] le
    );
        calc_end = (le == '0 || le > len) ? len : le;
    endfunction

    function automatic logic [FW-1:0] calc_start(
        input logic [FW:0]   endv,
        input logic [FW-1:0] ls
    );
        calc_start = ({1'b0, ls} < endv) ? ls : '0;
    endfunction

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    state_e state_q, state_d;
    cmd_e   pend_q, cmd_in, cmd_cur, cmd_apply;

    logic            busy_q, mode_rec_q, od_q, od_req;
    logic [EW-1:0]   eng_cnt;
    logic [FW-1:0]   wr_ptr, rd_ptr, win_start;
    logic [FW:0]     rec_len_q, end_q, base_len, len_inc, win_end, rd_nxt;
    logic            rec_done, full, frame_end, out_fire, tick_ok, tick_drop;
    logic            rb_en, rd_last, wa_en;
    logic [ADDR_WIDTH-1:0] wa_addr, rb_addr;
    logic signed [DATA_WIDTH-1:0] wa_data;

    logic [DATA_WIDTH-1:0]        mem [DEPTH];
    logic signed [DATA_WIDTH-1:0] rec_p0 [NUM_CH];
    logic signed [DATA_WIDTH-1:0] q_p0, old_p1;
    logic signed [DATA_WIDTH-1:0] slot_p1 [NUM_CH];
    logic                         vld_p0, vld_p1, last_p1, last_p2;
    logic [CW-1:0]                idx_p0, idx_p1;
    logic [ADDR_WIDTH-1:0]        raddr_p0, addr_p1;

`ifdef REPLAY_OVERDUB_EN
    assign od_req = overdub;
`else
    logic unused_overdub;
    assign unused_overdub = overdub;
    assign od_req         = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Command arbitration and next state
    // -----------------------------------------------------------------------
    always_comb begin
        cmd_in = C_NONE;
        if (cmd_stop)
            cmd_in = C_STOP;
        else if (cmd_record)
            cmd_in = C_REC;
        else if (cmd_play)
            cmd_in = C_PLAY;

        // A pending command is only ever replaced by one of equal or higher
        // priority.
        cmd_cur = (cmd_in > pend_q) ? cmd_in : pend_q;

        rec_done  = busy_q && mode_rec_q && (eng_cnt == CNT_LAST);
        len_inc   = rec_len_q + (FW+1)'(1);
        full      = rec_done && (len_inc == LEN_FULL);
        out_fire  = busy_q && !mode_rec_q && (od_q ? last_p2 : last_p1);
        frame_end = rec_done || out_fire;
        cmd_apply = (!busy_q || frame_end) ? cmd_cur : C_NONE;

        // Commands are applied on top of the state the finishing frame
        // leaves behind, so a play right after the last record frame sees
        // the updated length.
        base_len = rec_done ? len_inc : rec_len_q;
        state_d  = full ? S_IDLE : state_q;
        case (cmd_apply)
            C_STOP:  state_d = S_IDLE;
            C_REC:   state_d = S_RECORD;
            C_PLAY:  if (base_len != '0) state_d = S_PLAY;
            default: ;
        endcase

        win_end   = calc_end(base_len, loop_end);
        win_start = calc_start(win_end, loop_start);

        tick_ok   = sample_tick && !busy_q && (cmd_apply == C_NONE) &&
                    (state_q != S_IDLE);
        tick_drop = sample_tick && busy_q;
    end

    // -----------------------------------------------------------------------
    // RAM port control
    // -----------------------------------------------------------------------
    always_comb begin
        rb_en   = busy_q && !mode_rec_q && (eng_cnt <= CNT_LAST);
        rb_addr = make_addr(rd_ptr, CW'(eng_cnt));
        rd_last = rb_en && (eng_cnt == CNT_LAST);
        rd_nxt  = {1'b0, rd_ptr} + (FW+1)'(1);

        wa_en   = 1'b0;
        wa_addr = make_addr(wr_ptr, CW'(eng_cnt));
        wa_data = rec_p0[CW'(eng_cnt)];
        if (busy_q && mode_rec_q && (eng_cnt <= CNT_LAST)) begin
            wa_en = 1'b1;
        end else if (vld_p1 && od_q) begin
            wa_en   = 1'b1;
            wa_addr = addr_p1;
            wa_data = sat_add(old_p1, rec_p0[idx_p1]);
        end
        // Reset in the middle of a frame must not let the current word land.
        if (rst)
            wa_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wa_en)
            mem[wa_addr] <= wa_data;
    end

    // Stage p0: registered read data from port B
    always_ff @(posedge clk) begin
        if (rb_en)
            q_p0 <= mem[rb_addr];
    end

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pend_q     <= C_NONE;
            busy_q     <= 1'b0;
            mode_rec_q <= 1'b0;
            od_q       <= 1'b0;
            eng_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rec_len_q  <= '0;
            end_q      <= '0;
            overrun    <= 1'b0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            last_p2    <= 1'b0;
            play_valid <= 1'b0;
            play_data  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= (busy_q && !frame_end) ? cmd_cur : C_NONE;

            vld_p0  <= rb_en;
            vld_p1  <= vld_p0;
            last_p1 <= vld_p0 && (idx_p0 == CH_LAST);
            last_p2 <= last_p1;

            if (busy_q)
                eng_cnt <= eng_cnt + EW'(1);
            if (frame_end)
                busy_q <= 1'b0;
            if (tick_ok) begin
                busy_q     <= 1'b1;
                eng_cnt    <= '0;
                mode_rec_q <= (state_q == S_RECORD);
                od_q       <= od_req && (state_q == S_PLAY);
            end

            if (rec_done) begin
                wr_ptr    <= wr_ptr + FW'(1);
                rec_len_q <= len_inc;
            end

            // The window is re-evaluated at every wrap so loop edits take
            // effect on the next pass.
            if (rd_last) begin
                if (rd_nxt >= end_q) begin
                    rd_ptr <= win_start;
                    end_q  <= win_end;
                end else begin
                    rd_ptr <= rd_nxt[FW-1:0];
                end
            end

            play_valid <= out_fire && (state_d == S_PLAY);
            if (out_fire && (state_d == S_PLAY)) begin
                for (int c = 0; c < NUM_CH; c++)
                    play_data[c*DATA_WIDTH +: DATA_WIDTH] <= slot_p1[c];
            end else if (state_d == S_IDLE) begin
                play_data <= '0;
            end

            if (tick_drop)
                overrun <= 1'b1;

            case (cmd_apply)
                C_STOP: overrun <= 1'b0;
                C_REC: begin
                    wr_ptr    <= '0;
                    rec_len_q <= '0;
                end
                C_PLAY: begin
                    if (base_len != '0) begin
                        rd_ptr <= win_start;
                        end_q  <= win_end;
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (tick_ok) begin
            for (int c = 0; c < NUM_CH; c++)
                rec_p0[c] <= rec_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
        idx_p0   <= CW'(eng_cnt);
        raddr_p0 <= rb_addr;

        // Stage p1: frame assembly and overdub write-back operands
        if (vld_p0)
            slot_p1[idx_p0] <= q_p0;
        idx_p1  <= idx_p0;
        addr_p1 <= raddr_p0;
        old_p1  <= q_p0;
    end

    assign state   = state_q;
    assign rec_len = rec_len_q;
    assign busy    = busy_q;

endmodule

// File: doc/replay_loop_buffer.md
Name: replay_loop_buffer

Overview:
Parametrised multi-channel record/playback loop buffer for the music player's replay path.
- Owns a true dual-port block RAM organised as frames of NUM_CH interleaved signed samples.
- Records incoming frames on sample_tick, then replays a selectable loop window continuously.
- Sits between the audio sample source and the output mixer.

Parameters:
ADDR_WIDTH, 17, word address width; RAM depth 2**ADDR_WIDTH words
DATA_WIDTH, 16, signed sample width
NUM_CH, 2, channels per frame; power of two, >=1; FRAMES = 2**ADDR_WIDTH/NUM_CH; FW = log2(FRAMES)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sample_tick  in  1  one-cycle frame strobe
cmd_record  in  1  pulse: start recording
cmd_play  in  1  pulse: start playback
cmd_stop  in  1  pulse: return to IDLE
overdub  in  1  level: mix rec_data into loop during PLAY (feature-gated)
rec_data  in  NUM_CH*DATA_WIDTH  frame in; ch0 in LSBs
loop_start  in  FW  first frame of loop window
loop_end  in  FW+1  exclusive end frame; 0 = use rec_len
play_data  out  NUM_CH*DATA_WIDTH  frame out; ch0 in LSBs
play_valid  out  1  one-cycle pulse: new play_data
state  out  2  0=IDLE, 1=RECORD, 2=PLAY
rec_len  out  FW+1  frames recorded
busy  out  1  frame engine active
overrun  out  1  sticky: tick dropped

Behaviour:
- Reset values: state IDLE; play_data 0; play_valid 0; rec_len 0; busy 0; overrun 0; pointers 0. Mid-frame reset aborts the frame and suppresses its remaining writes. RAM contents are not cleared.
- Word address = {frame_ptr, ch_idx}.
- Port A carries record and overdub writes. Port B carries playback reads.
- Command priority: stop > record > play.
  - A command arriving while busy is latched as pending and applied in the cycle busy falls.
  - A later command in the same busy window overrides the pending one, by priority.
- IDLE:
  - cmd_record -> RECORD; wr_ptr=0, rec_len=0.
  - cmd_play with rec_len!=0 -> PLAY; cmd_play with rec_len==0 is ignored.
  - Entering IDLE forces play_data to 0.
- Record frame, tick captured at cycle T:
  - rec_data is registered at T.
  - Word k is written at T+1+k.
  - At T+NUM_CH: wr_ptr and rec_len increment; busy falls after that cycle.
  - When rec_len reaches FRAMES: auto-transition to IDLE, rec_len holds at FRAMES.
- PLAY:
  - end_eff = (loop_end==0 or loop_end>rec_len) ? rec_len : loop_end.
  - start_eff = (loop_start<end_eff) ? loop_start : 0.
  - Both are recomputed on PLAY entry and at each wrap; rd_ptr = start_eff on entry.
- Play frame, tick at T:
  - Read word k at T+1+k; data returns at T+2+k.
  - play_data updates and play_valid pulses at T+NUM_CH+2, all channels together.
  - rd_ptr increments; rd_ptr==end_eff wraps to start_eff.
- busy is high from T+1 through the last engine cycle of the frame.
  - Minimum tick spacing: NUM_CH+3 cycles; NUM_CH+4 with overdub.
- sample_tick while busy, or in the same cycle busy falls:
  - The tick is dropped and overrun is set.
  - overrun is cleared only by rst or cmd_stop.
- sample_tick in IDLE: ignored; overrun is not set.
- play_valid is never asserted outside PLAY.

Optional Feature:
REPLAY_OVERDUB_EN
- Defined: in PLAY with overdub=1 at the tick:
  - Each word read at T+2+k is written back at T+3+k to the same address via port A.
  - Written value = saturate(old + rec_data[k]), clamped to [-2^(DW-1), 2^(DW-1)-1].
  - play_data carries the pre-mix old values; play_valid moves to T+NUM_CH+3.
- Undefined: the overdub port is ignored, no port-A writes occur in PLAY, and timing is as above.

Test Plan:
- Reset with NUM_CH=2, ADDR_WIDTH=4 -> state=0, play_data=0, play_valid=0, rec_len=0, busy=0, overrun=0.
- Record frames (100,-100), (200,-200), (300,-300), stop, play with loop_start=0, loop_end=0, ticks every 8 cycles -> play_data sequence 100/-100, 200/-200, 300/-300, 100/-100...; play_valid at T+4 after each tick.
- Record 10 ticks, 8 frames max -> rec_len=8 after the 8th frame; state=IDLE; ticks 9-10 ignored, overrun stays 0.
- Loop window checks:
  - loop_start=1, loop_end=2 -> frame 1 repeats.
  - loop_start=5, loop_end=2 -> start_eff=0, loop plays frames 0,1.
- Ticks 2 cycles apart in PLAY -> second tick dropped, overrun=1; cmd_stop -> overrun=0, state=0, play_data=0.
- REPLAY_OVERDUB_EN defined:
  - stored 32000 + input 1000 -> output 32000, RAM becomes 32767.
  - stored -32000 + input -1000 -> RAM becomes -32768.
  - Next loop pass outputs the saturated values.
